// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the round-robin mux scheduler: state encoding,
// requester count and select width.
package mux_rr_scheduler_pkg;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [ADDR_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_rr_priority_pick.sv
// Combinational round-robin pick: rotate requests so Last+1 sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_priority_pick
  import mux_rr_scheduler_pkg::*;
(
  input  logic [N_REQ-1:0]  Req,
  input  logic [ADDR_W-1:0] Last,
  output logic [ADDR_W-1:0] Pick,
  output logic              Any
);

  logic [ADDR_W-1:0] start;
  logic [N_REQ-1:0]  rot;
  logic [ADDR_W-1:0] offs;

  always_comb begin
    start = Last + ADDR_W'(1);
    rot   = '0;
    offs  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      rot[j] = Req[start + ADDR_W'(j)];
    end
    // Descending scan so the lowest rotated position wins.
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) offs = ADDR_W'(j);
    end
    Pick = start + offs;
    Any  = |Req;
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving the select of a shared 4:1 mux: bounded
// bursts per requester, an idle gap between bursts, all outputs registered.
module mux_rr_scheduler
  import mux_rr_scheduler_pkg::*;
#(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Enable,
  input  logic [N_REQ-1:0]  Req,
  output logic [N_REQ-1:0]  Grant,
  output logic [ADDR_W-1:0] Address,
  output logic              Valid
);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] last, last_d;
  logic [N_REQ-1:0]  grant_d;
  logic [ADDR_W-1:0] addr_d;
  logic              valid_d;

  logic [ADDR_W-1:0] pick;
  logic              any;
  logic              start_grant;
  logic              end_grant;
  logic              gap_done;

  rr_priority_pick u_pick (
    .Req  (Req),
    .Last (last),
    .Pick (pick),
    .Any  (any)
  );

  // The last gap cycle arbitrates directly, so GAP_CYCLES is the exact
  // number of dead cycles between consecutive grants.
  always_comb begin
    gap_done    = (state == ST_GAP) && (cnt == CNT_W'(GAP_CYCLES));
    start_grant = ((state == ST_IDLE) || gap_done) && Enable && any;
    end_grant   = (state == ST_BUSY) &&
                  (!Req[Address] || (cnt == CNT_W'(MAX_HOLD)));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      last    <= ADDR_W'(N_REQ - 1);
      Grant   <= '0;
      Address <= '0;
      Valid   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      last    <= last_d;
      Grant   <= grant_d;
      Address <= addr_d;
      Valid   <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (start_grant) state_d = ST_BUSY;
      ST_BUSY: if (end_grant)   state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:  if (gap_done)    state_d = start_grant ? ST_BUSY : ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt;
    last_d  = last;
    grant_d = Grant;
    addr_d  = Address;
    valid_d = Valid;
    if (start_grant) begin
      grant_d = onehot(pick);
      addr_d  = pick;
      valid_d = 1'b1;
      cnt_d   = CNT_W'(1);
    end else if (end_grant) begin
      grant_d = '0;
      valid_d = 1'b0;
      last_d  = Address;
      cnt_d   = CNT_W'(1);
    end else if (state == ST_BUSY || (state == ST_GAP && !gap_done)) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: inputs driven and outputs sampled on
// the falling edge, expected values written out per step.
module tb_mux_rr_scheduler;
  import mux_rr_scheduler_pkg::*;

  logic       Clk;
  logic       Reset_n;
  logic       Enable;
  logic [3:0] Req;
  logic [3:0] Grant;
  logic [1:0] Address;
  logic       Valid;

  int checks   = 0;
  int failures = 0;

  mux_rr_scheduler #(.MAX_HOLD(8), .GAP_CYCLES(1), .CNT_W(4)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Enable  (Enable),
    .Req     (Req),
    .Grant   (Grant),
    .Address (Address),
    .Valid   (Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] a,
                     input logic v);
    checks++;
    assert (Grant === g) else begin
      failures++;
      $error("FAIL %s grant observed=%b expected=%b", tag, Grant, g);
    end
    checks++;
    assert (Address === a) else begin
      failures++;
      $error("FAIL %s address observed=%b expected=%b", tag, Address, a);
    end
    checks++;
    assert (Valid === v) else begin
      failures++;
      $error("FAIL %s valid observed=%b expected=%b", tag, Valid, v);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    Req     = 4'b1111;
    Enable  = 1'b1;

    // Held in reset with all requests asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_hold", 4'b0000, 2'd0, 1'b0);
    end

    // Lone requester 2: 8-cycle burst, 1-cycle gap, re-grant
    Reset_n = 1'b1;
    Req     = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk("solo_burst", 4'b0100, 2'd2, 1'b1);
    end
    @(negedge Clk);
    chk("solo_gap", 4'b0000, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("solo_regrant", 4'b0100, 2'd2, 1'b1);
    end

    // Async reset pulse between edges mid-burst
    #1 Reset_n = 1'b0;
    #1 chk("async_rst", 4'b0000, 2'd0, 1'b0);
    #1 Reset_n = 1'b1;
    Req = 4'b1111;

    // All requesting: order 0,1,2,3,0 with gaps
    for (int g = 0; g < 5; g++) begin
      logic [1:0] gi;
      logic [3:0] go;
      gi = 2'(g % 4);
      go = 4'b0001 << gi;
      for (int i = 0; i < 8; i++) begin
        @(negedge Clk);
        chk("rr_burst", go, gi, 1'b1);
      end
      @(negedge Clk);
      chk("rr_gap", 4'b0000, gi, 1'b0);
    end

    // Grant to 1, release after 3 cycles, next goes to 3
    Req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("drop_burst", 4'b0010, 2'd1, 1'b1);
    end
    Req = 4'b1001;
    @(negedge Clk);
    chk("drop_gap", 4'b0000, 2'd1, 1'b0);
    @(negedge Clk);
    chk("drop_next", 4'b1000, 2'd3, 1'b1);

    // Finish burst on 3, then Enable dropped during burst on 0
    Req = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      chk("pre_en_burst", 4'b1000, 2'd3, 1'b1);
    end
    @(negedge Clk);
    chk("pre_en_gap", 4'b0000, 2'd3, 1'b0);
    @(negedge Clk);
    chk("en_burst", 4'b0001, 2'd0, 1'b1);
    Enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      chk("en_burst", 4'b0001, 2'd0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("en_off_idle", 4'b0000, 2'd0, 1'b0);
    end
    Enable = 1'b1;
    @(negedge Clk);
    chk("en_resume", 4'b0010, 2'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
